// File: rtl/gf_pkg.sv
// Shared types and constants for the GF exponentiation engine.
// GF_EXP_CT_EN selects the constant-time ladder, which has no SCAN state.
package gf_pkg;

  localparam int unsigned BW_GF = 256;
  localparam logic [BW_GF-1:0] GF_ONE = BW_GF'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifndef GF_EXP_CT_EN
    StScan,
`endif
    StMulX,
    StWaitX,
    StMulS,
    StWaitS,
    StDone
  } gf_state_e;

endpackage

// File: rtl/gf_exp_bitsel.sv
// Exponent buffer and bit counter, walking the exponent MSB first.
// GF_EXP_CT_EN removes the first-one detect used by the leading-zero skip.
module gf_exp_bitsel
  import gf_pkg::*;
#(
  parameter int unsigned EW = BW_GF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [EW-1:0] exp_i,
  input  logic          dec_i,
  output logic          bit_o,
  output logic          last_o
`ifndef GF_EXP_CT_EN
  ,
  output logic          first_o
`endif
);

  localparam int unsigned IW = $clog2(EW + 1);

  logic [EW-1:0] ebuf_q, ebuf_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    ebuf_d = ebuf_q;
    idx_d  = idx_q;
    if (load_i) begin
      ebuf_d = exp_i;
      idx_d  = IW'(EW - 1);
    end else if (dec_i) begin
      idx_d = idx_q - IW'(1);
    end
  end

  always_comb begin
    bit_o = 1'b0;
    for (int unsigned i = 0; i < EW; i++) begin
      if (idx_q == IW'(i)) bit_o = ebuf_q[i];
    end
  end

  assign last_o = (idx_q == '0);

`ifndef GF_EXP_CT_EN
  // Current bit set with every higher bit clear.
  assign first_o = ((ebuf_q >> idx_q) == EW'(1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ebuf_q <= '0;
      idx_q  <= '0;
    end else begin
      ebuf_q <= ebuf_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/gf_exp_ladder.sv
// Modular exponentiation sequencer (base^exp mod p) driving an external modular multiplier.
// Define GF_EXP_CT_EN for the constant-time Montgomery ladder; otherwise square-and-multiply.
module gf_exp_ladder
  import gf_pkg::*;
#(
  parameter int unsigned W  = BW_GF,
  parameter int unsigned EW = BW_GF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  output logic          ready,
  output logic          busy,
  output logic [W-1:0]  result,
  output logic          valid,
  output logic          mul_start,
  output logic [W-1:0]  mul_a,
  output logic [W-1:0]  mul_b,
  input  logic [W-1:0]  mul_prod,
  input  logic          mul_valid
);

  gf_state_e    state_q, state_d;
  logic [W-1:0] r0_q, r0_d, r1_q, r1_d, t_q, t_d, result_q, result_d;
  logic [W-1:0] mul_a_q, mul_b_q, op_a, op_b;
  logic         pend_q, pend_d, mul_ok;
  logic         bs_load, bs_dec, bs_bit, bs_last;
`ifndef GF_EXP_CT_EN
  logic         bs_first;
`endif

  gf_exp_bitsel #(
    .EW(EW)
  ) u_bitsel (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (bs_load),
    .exp_i  (exp),
    .dec_i  (bs_dec),
    .bit_o  (bs_bit),
`ifndef GF_EXP_CT_EN
    .first_o(bs_first),
`endif
    .last_o (bs_last)
  );

  assign ready  = (state_q == StIdle) && !pend_q;
  assign busy   = (state_q != StIdle);
  assign mul_ok = mul_valid && pend_q;

  always_comb begin
    state_d   = state_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    t_d       = t_q;
    bs_load   = 1'b0;
    bs_dec    = 1'b0;
    mul_start = 1'b0;
    valid     = 1'b0;
    op_a      = r0_q;
    op_b      = r1_q;
    if (busy && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && ready) begin
            // base is held in R1 from acceptance onward.
            r1_d    = base;
            bs_load = 1'b1;
            state_d = StLoad;
          end
        end
        StLoad: begin
          r0_d = W'(GF_ONE);
`ifdef GF_EXP_CT_EN
          state_d = StMulX;
`else
          state_d = StScan;
`endif
        end
`ifdef GF_EXP_CT_EN
        StMulX: begin
          mul_start = 1'b1;
          state_d   = StWaitX;
        end
        StWaitX: begin
          if (mul_ok) begin
            t_d     = mul_prod;
            state_d = StMulS;
          end
        end
        StMulS: begin
          op_a      = bs_bit ? r1_q : r0_q;
          op_b      = op_a;
          mul_start = 1'b1;
          state_d   = StWaitS;
        end
        StWaitS: begin
          if (mul_ok) begin
            if (bs_bit) begin
              r1_d = mul_prod;
              r0_d = t_q;
            end else begin
              r0_d = mul_prod;
              r1_d = t_q;
            end
            bs_dec  = !bs_last;
            state_d = bs_last ? StDone : StMulX;
          end
        end
`else
        StScan: begin
          if (bs_first) r0_d = r1_q;
          bs_dec = !bs_last;
          if (bs_last) state_d = StDone;
          else if (bs_first) state_d = StMulS;
        end
        StMulX: begin
          mul_start = 1'b1;
          state_d   = StWaitX;
        end
        StWaitX: begin
          if (mul_ok) begin
            r0_d    = mul_prod;
            bs_dec  = !bs_last;
            state_d = bs_last ? StDone : StMulS;
          end
        end
        StMulS: begin
          op_b      = r0_q;
          mul_start = 1'b1;
          state_d   = StWaitS;
        end
        StWaitS: begin
          if (mul_ok) begin
            r0_d = mul_prod;
            if (bs_bit) begin
              state_d = StMulX;
            end else begin
              bs_dec  = !bs_last;
              state_d = bs_last ? StDone : StMulS;
            end
          end
        end
`endif
        StDone: begin
          valid   = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    pend_d = pend_q;
    if (mul_start) pend_d = 1'b1;
    else if (mul_ok) pend_d = 1'b0;

    // Operands come straight from R registers on the issue cycle, then from the hold copy.
    mul_a    = mul_start ? op_a : mul_a_q;
    mul_b    = mul_start ? op_b : mul_b_q;
    result   = valid ? r0_q : result_q;
    result_d = result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      r0_q     <= '0;
      r1_q     <= '0;
      t_q      <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      t_q      <= t_d;
      result_q <= result_d;
      mul_a_q  <= mul_a;
      mul_b_q  <= mul_b;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: doc/gf_exp_ladder.md
# gf_exp_ladder

Parametrised modular exponentiation engine computing result = base^exp mod p. It is the successor to the scalar-bit sequencer of the EC point unit, generalised to W-bit operands, an EW-bit exponent and a selectable constant-time mode. It owns no multiplier. It drives a shared modular multiplier port with a start/valid handshake, so it can run Fermat inversion (exp = p-2) beside or in place of the dedicated inverse block.

## Interface
- W, 256, field element width; p is fixed inside the attached multiplier
- EW, 256, exponent width; the bit counter is $clog2(EW+1) bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- abort  in  1  synchronous cancel of the running job
- base  in  W  operand, must be < p; sampled with start
- exp  in  EW  exponent; sampled with start
- ready  out  1  block can accept start
- busy  out  1  job in progress
- result  out  W  base^exp mod p; held until the next accepted start
- valid  out  1  one-cycle pulse; result is valid in the same cycle
- mul_start  out  1  one-cycle pulse issuing mul_a*mul_b
- mul_a, mul_b  out  W  multiplier operands, stable from the mul_start cycle until mul_valid
- mul_prod  in  W  reduced product, valid when mul_valid=1
- mul_valid  in  1  one-cycle pulse, L≥1 cycles after mul_start

## Operation
- Registers:
  - R0 and R1: W bits each.
  - T: W bits.
  - ebuf: EW bits, latched copy of exp.
  - idx: bit counter.
  - pend: 1 bit, a multiply is outstanding.
- States: IDLE, LOAD, SCAN (non-CT only), MUL_X, WAIT_X, MUL_S, WAIT_S, DONE.
- IDLE: start && ready moves to LOAD. LOAD sets R0=1, R1=base, idx=EW-1.
- Constant-time ladder, one step per bit b=ebuf[idx], MSB first:
  - MUL_X: issue R0*R1. WAIT_X: on mul_valid, T=mul_prod.
  - MUL_S: issue R_b*R_b. WAIT_S: on mul_valid, R_b=mul_prod and R_~b=T.
  - Then go to MUL_X if idx>0 (idx decrements), else DONE.
- Non-CT square-and-multiply:
  - SCAN tests one bit per cycle from the MSB.
  - At the first 1: R0=base and decrement idx. If that bit was idx 0, go to DONE.
  - For each remaining bit: square R0 via MUL_S/WAIT_S. If the bit is 1, also R0=R0*base via MUL_X/WAIT_X.
  - exp=0: SCAN runs out and goes to DONE with R0=1.
- DONE: result=R0, valid=1 for one cycle, then IDLE.
- mul_a/mul_b are driven from registers only, never from mul_prod combinationally.
- Abort:
  - Any non-IDLE state goes to IDLE on the next edge. No valid pulse; result is unchanged.
  - If pend=1, ready stays 0 until the stray mul_valid arrives. That stray mul_valid is discarded.
- mul_valid with pend=0 is ignored.
- start while ready=0 is ignored, with no queueing.
- abort and start in the same cycle: abort wins if busy; in IDLE, abort is ignored.
- Reset, async and valid at any point: state=IDLE, pend=0, R0/R1/T=0, result=0, valid=0, busy=0, ready=1, mul_start=0, mul_a=mul_b=0.

## Timing
- Cycle 0 is the cycle in which start is sampled; LOAD runs in cycle 1.
- Each multiply takes 1+L cycles: the MUL_* cycle plus wait cycles up to and including the mul_valid cycle.
- CT mode: valid is asserted in cycle 2+2·EW·(1+L), independent of base and exp.
- Non-CT mode:
  - Latency is 2 + z + 1 + (EW-z-1)(1+L) + h(1+L), where z is the number of leading zeros and h is the popcount of the bits below the leading 1.
  - exp=0 gives valid in cycle 2+EW.
- busy=1 from cycle 1 through the DONE cycle inclusive.
- ready=0 while busy or pend; ready=1 is restored in the cycle after DONE.

## Configuration
- GF_EXP_CT_EN defined: Montgomery ladder, fixed latency and fixed multiply pattern, no SCAN state.
- GF_EXP_CT_EN undefined: square-and-multiply with leading-zero skip, data-dependent latency, roughly 25% fewer multiplies on average.

## Structure
- The shared package gf_pkg holds:
  - The default BW_GF width.
  - The state enum.
  - The constant GF_ONE.
- One sub-module, gf_exp_bitsel, is natural:
  - Holds ebuf and idx.
  - Provides load, decrement, current bit, last flag, and in non-CT mode the first-one detect.
- The multiplier stays outside this block.

## Test plan
Bench setup: W=EW=8, behavioural multiplier mod p=251 with L=3.
- base=3, exp=5 → result=243. In CT mode valid arrives exactly at cycle 66.
- base=5, exp=249 → result=201 (inverse of 5). base=2, exp=250 → result=1.
- exp=0 with base=7 → result=1. exp=0 with base=0 → 1. base=0, exp=3 → 0.
- CT mode, exp=0x01 vs exp=0xFF with any base → identical valid cycle (66) and identical mul_start cycle pattern.
- abort 2 cycles after a mul_start:
  - no valid pulse; ready stays low until the stray mul_valid and rises the cycle after;
  - a following start with base=3, exp=5 returns 243.
- rst_n low mid-WAIT_S → all outputs return to reset values immediately (asynchronous); mul_valid arriving during or after reset is ignored.
